// File: rtl/ob_ctlr_pkg.sv
// Shared types and widths for the outbound C2H controller.
package ob_ctlr_pkg;

  typedef enum logic [1:0] {IDLE, ARB, STREAM, DONE} state_t;

  localparam int unsigned C2H_DW   = 64;
  localparam int unsigned RAM_DW   = 128;
  localparam logic [7:0]  KEEP_ALL = 8'hFF;

endpackage

// File: rtl/ob_rd_fifo.sv
// Two-entry word FIFO between the RAM read port and the beat serialiser.
module ob_rd_fifo
  import ob_ctlr_pkg::*;
#(
  parameter int unsigned DW = RAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [1:0]    count,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage is deliberately left out of reset; only occupancy is cleared.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ob_ctlr.sv
// Outbound C2H controller: round-robin drains full 128-bit RAM buffers
// onto a 64-bit AXI-Stream, two beats per word, tlast on the final beat.
module ob_ctlr
  import ob_ctlr_pkg::*;
#(
  parameter int unsigned NUM_BUF   = 8,
  parameter int unsigned BUF_WORDS = 64,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BUF-1:0]  RamValid,
  output logic [NUM_BUF-1:0]  BufDone,
  output logic                RdEn,
  output logic [31:0]         RdAddr,
  input  logic [RAM_DW-1:0]   RdData,
  output logic [C2H_DW-1:0]   s_axis_c2h_tdata_0,
  output logic [C2H_DW/8-1:0] s_axis_c2h_tkeep_0,
  output logic                s_axis_c2h_tlast_0,
  output logic                s_axis_c2h_tvalid_0,
  input  logic                s_axis_c2h_tready_0,
  output logic                Busy
);

  localparam int unsigned PTR_W = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam int unsigned WC_W  = $clog2(BUF_WORDS + 1);

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   cur_buf;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   cand;
  logic               grant_ok;
  logic [WC_W-1:0]    word_cnt;
  logic [WC_W-1:0]    out_cnt;
  logic               half;
  logic [RD_LAT-1:0]  rd_pipe;
  logic [1:0]         fifo_count;
  logic [RAM_DW-1:0]  fifo_dout;
  logic               hs;
  logic               last_hs;

  // Words in flight or buffered never exceed the two FIFO slots.
  ob_rd_fifo #(.DW(RAM_DW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_pipe[RD_LAT-1]),
    .din   (RdData),
    .pop   (hs && half),
    .count (fifo_count),
    .dout  (fifo_dout)
  );

  assign s_axis_c2h_tvalid_0 = (fifo_count != 2'd0);
  assign s_axis_c2h_tkeep_0  = KEEP_ALL;
  assign s_axis_c2h_tdata_0  = !s_axis_c2h_tvalid_0 ? '0 :
                               half ? fifo_dout[RAM_DW-1:C2H_DW] : fifo_dout[C2H_DW-1:0];
  assign s_axis_c2h_tlast_0  = s_axis_c2h_tvalid_0 && half && (out_cnt == WC_W'(BUF_WORDS - 1));
  assign hs      = s_axis_c2h_tvalid_0 && s_axis_c2h_tready_0;
  assign last_hs = hs && s_axis_c2h_tlast_0;
  assign RdAddr  = 32'(cur_buf) * 32'(BUF_WORDS) + 32'(word_cnt);

  // First requesting buffer at or after rr_ptr, wrapping.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = rr_ptr;
    cand      = rr_ptr;
    for (int unsigned off = 0; off < NUM_BUF; off++) begin
      cand = rr_ptr + PTR_W'(off);
      if (!grant_ok && RamValid[cand]) begin
        grant_ok  = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|RamValid) state_nxt = ARB;
      ARB:     state_nxt = grant_ok ? STREAM : IDLE;
      STREAM:  if (last_hs) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    RdEn    = (state == STREAM) &&
              ((int'(fifo_count) + $countones(rd_pipe)) < 2) &&
              (word_cnt < WC_W'(BUF_WORDS));
    BufDone = (state == DONE) ? (NUM_BUF'(1) << cur_buf) : '0;
    Busy    = (state == STREAM) || (state == DONE) || ((state == ARB) && grant_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      cur_buf  <= '0;
      word_cnt <= '0;
      out_cnt  <= '0;
      half     <= 1'b0;
      rd_pipe  <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | RD_LAT'(RdEn);
      if (state == ARB && grant_ok) begin
        cur_buf  <= grant_idx;
        word_cnt <= '0;
        out_cnt  <= '0;
        half     <= 1'b0;
      end else begin
        if (RdEn) word_cnt <= word_cnt + WC_W'(1);
        if (hs) begin
          half <= ~half;
          if (half) out_cnt <= out_cnt + WC_W'(1);
        end
      end
      if (state == DONE) rr_ptr <= cur_buf + PTR_W'(1);
    end
  end

endmodule
